// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-ported 64-bit data memory. Requester 0 has fixed priority,
// and a starvation counter forces a grant to requester 1. Illegal addresses return an error response.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES    = 1024,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [63:0] r0_addr,
    input  logic [63:0] r0_wdata,
    output logic        r0_gnt,
    output logic        r0_done,
    output logic        r0_err,
    output logic [63:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [63:0] r1_addr,
    input  logic [63:0] r1_wdata,
    output logic        r1_gnt,
    output logic        r1_done,
    output logic        r1_err,
    output logic [63:0] r1_rdata,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_read_data
);

    localparam logic [63:0] MAX_ADDR   = 64'(MEM_BYTES - 8);
    localparam logic [7:0]  STARVE_LIM = 8'(STARVE_LIMIT);
    localparam logic [7:0]  STARVE_MAX = 8'd255;

    typedef enum logic [1:0] {IDLE, SERVE, RESP} state_t;

    state_t      state;
    logic        lat_we;
    logic        lat_id;
    logic [63:0] lat_addr;
    logic [63:0] lat_wdata;
    logic [7:0]  starve_cnt;
    logic        pick1;
    logic        legal;

    // Arbitration is open in IDLE and RESP; memory strobes only in SERVE, gated by reset
    always_comb begin
        pick1          = r1_req && ((starve_cnt >= STARVE_LIM) || !r0_req);
        r1_gnt         = (state != SERVE) && pick1;
        r0_gnt         = (state != SERVE) && r0_req && !pick1;
        legal          = (lat_addr <= MAX_ADDR) && (lat_addr[2:0] == 3'b000);
        mem_address    = 64'd0;
        mem_write_data = 64'd0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        if (state == SERVE && rst_n) begin
            mem_address    = lat_addr;
            mem_write_data = lat_wdata;
            mem_write      = legal && lat_we;
            mem_read       = legal && !lat_we;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            starve_cnt <= 8'd0;
            lat_we     <= 1'b0;
            lat_id     <= 1'b0;
            lat_addr   <= 64'd0;
            lat_wdata  <= 64'd0;
            r0_done    <= 1'b0;
            r0_err     <= 1'b0;
            r0_rdata   <= 64'd0;
            r1_done    <= 1'b0;
            r1_err     <= 1'b0;
            r1_rdata   <= 64'd0;
        end else begin
            r0_done <= 1'b0;
            r0_err  <= 1'b0;
            r1_done <= 1'b0;
            r1_err  <= 1'b0;

            if (!r1_req || r1_gnt) begin
                starve_cnt <= 8'd0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 8'd1;
            end

            case (state)
                IDLE, RESP: begin
                    if (r1_gnt) begin
                        lat_we    <= r1_we;
                        lat_id    <= 1'b1;
                        lat_addr  <= r1_addr;
                        lat_wdata <= r1_wdata;
                        state     <= SERVE;
                    end else if (r0_gnt) begin
                        lat_we    <= r0_we;
                        lat_id    <= 1'b0;
                        lat_addr  <= r0_addr;
                        lat_wdata <= r0_wdata;
                        state     <= SERVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                SERVE: begin
                    state <= RESP;
                    if (lat_id) begin
                        r1_done <= 1'b1;
                        r1_err  <= !legal;
                        if (!legal) begin
                            r1_rdata <= 64'd0;
                        end else if (!lat_we) begin
                            r1_rdata <= mem_read_data;
                        end
                    end else begin
                        r0_done <= 1'b1;
                        r0_err  <= !legal;
                        if (!legal) begin
                            r0_rdata <= 64'd0;
                        end else if (!lat_we) begin
                            r0_rdata <= mem_read_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1 KiB doubleword memory.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_req, r0_we, r0_gnt, r0_done, r0_err;
    logic [63:0] r0_addr, r0_wdata, r0_rdata;
    logic        r1_req, r1_we, r1_gnt, r1_done, r1_err;
    logic [63:0] r1_addr, r1_wdata, r1_rdata;
    logic [63:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    logic [63:0] tb_mem [0:127];
    int          n_cmp;
    int          n_err;

    dmem_arbiter #(.MEM_BYTES(1024), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on posedge
    assign mem_read_data = tb_mem[mem_address[9:3]];
    always @(posedge clk) begin
        if (mem_write) tb_mem[mem_address[9:3]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 128; i++) tb_mem[i] = 64'h0123_4567_0000_0000 + 64'(i);
        rst_n = 1'b0;
        r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
        r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
        tick(); tick();
        chk("rst_r0_done", 64'(r0_done), 64'd0);
        chk("rst_r1_err", 64'(r1_err), 64'd0);
        chk("rst_r0_rdata", r0_rdata, 64'd0);
        chk("rst_mem_wr", 64'(mem_write), 64'd0);
        rst_n = 1'b1;
        tick();

        // r0 write 16
        r0_req = 1; r0_we = 1; r0_addr = 64'd16; r0_wdata = 64'h1122334455667788;
        #1;
        chk("w_r0_gnt", 64'(r0_gnt), 64'd1);
        chk("w_r1_gnt", 64'(r1_gnt), 64'd0);
        tick();
        r0_req = 0;
        chk("w_mem_write", 64'(mem_write), 64'd1);
        chk("w_mem_read", 64'(mem_read), 64'd0);
        chk("w_mem_addr", mem_address, 64'd16);
        chk("w_mem_wdata", mem_write_data, 64'h1122334455667788);
        chk("w_serve_gnt", 64'(r0_gnt), 64'd0);
        tick();
        chk("w_r0_done", 64'(r0_done), 64'd1);
        chk("w_r0_err", 64'(r0_err), 64'd0);
        chk("w_resp_mem_wr", 64'(mem_write), 64'd0);
        tick();
        chk("w_done_pulse", 64'(r0_done), 64'd0);

        // r0 read 16
        r0_req = 1; r0_we = 0; r0_addr = 64'd16;
        tick();
        r0_req = 0;
        chk("r_mem_read", 64'(mem_read), 64'd1);
        tick();
        chk("r_r0_done", 64'(r0_done), 64'd1);
        chk("r_r0_rdata", r0_rdata, 64'h1122334455667788);
        tick();

        // r1 legal read at top address, then illegal reads
        r1_req = 1; r1_we = 0; r1_addr = 64'd1016;
        #1 chk("top_r1_gnt", 64'(r1_gnt), 64'd1);
        tick(); r1_req = 0; tick();
        chk("top_r1_err", 64'(r1_err), 64'd0);
        chk("top_r1_rdata", r1_rdata, 64'h0123_4567_0000_007F);
        tick();
        r1_req = 1; r1_addr = 64'd1017;
        #1 chk("oor_r1_gnt", 64'(r1_gnt), 64'd1);
        tick(); r1_req = 0;
        chk("oor_mem_read", 64'(mem_read), 64'd0);
        tick();
        chk("oor_r1_done", 64'(r1_done), 64'd1);
        chk("oor_r1_err", 64'(r1_err), 64'd1);
        chk("oor_r1_rdata", r1_rdata, 64'd0);
        tick();
        r1_req = 1; r1_addr = 64'd12;
        tick(); r1_req = 0;
        chk("mis_mem_read", 64'(mem_read), 64'd0);
        tick();
        chk("mis_r1_done", 64'(r1_done), 64'd1);
        chk("mis_r1_err", 64'(r1_err), 64'd1);
        chk("mis_r1_rdata", r1_rdata, 64'd0);
        tick();

        // Both held: grants r0, r0, then r1 once starve_cnt reaches 4
        r0_req = 1; r0_we = 0; r0_addr = 64'd24;
        r1_req = 1; r1_we = 0; r1_addr = 64'd32;
        #1;
        chk("st0_r0_gnt", 64'(r0_gnt), 64'd1);
        chk("st0_r1_gnt", 64'(r1_gnt), 64'd0);
        tick();
        chk("st1_gnts", 64'({r0_gnt, r1_gnt}), 64'd0);
        tick();
        chk("st2_r0_gnt", 64'(r0_gnt), 64'd1);
        chk("st2_r1_gnt", 64'(r1_gnt), 64'd0);
        chk("st2_r0_rdata", r0_rdata, 64'h0123_4567_0000_0003);
        tick();
        tick();
        chk("st4_r1_gnt", 64'(r1_gnt), 64'd1);
        chk("st4_r0_gnt", 64'(r0_gnt), 64'd0);
        chk("st4_r0_done", 64'(r0_done), 64'd1);
        tick();
        r0_req = 0; r1_req = 0;
        tick();
        chk("st6_r1_done", 64'(r1_done), 64'd1);
        chk("st6_r1_rdata", r1_rdata, 64'h0123_4567_0000_0004);
        chk("st6_r0_done", 64'(r0_done), 64'd0);
        tick();
        // Starvation count cleared: simultaneous requests go to r0 again
        r0_req = 1; r1_req = 1;
        #1 chk("st_clr_r0_gnt", 64'(r0_gnt), 64'd1);
        tick(); r0_req = 0; r1_req = 0;
        tick(); tick();

        // Alternating: r0 read at T, r1 write in RESP at T+2
        r0_req = 1; r0_we = 0; r0_addr = 64'd8;
        tick(); r0_req = 0;
        tick();
        r1_req = 1; r1_we = 1; r1_addr = 64'd40; r1_wdata = 64'hCAFE_F00D_0000_0028;
        #1;
        chk("alt_r1_gnt", 64'(r1_gnt), 64'd1);
        chk("alt_r0_done", 64'(r0_done), 64'd1);
        chk("alt_r1_done0", 64'(r1_done), 64'd0);
        chk("alt_r0_rdata", r0_rdata, 64'h0123_4567_0000_0001);
        tick(); r1_req = 0;
        chk("alt_mem_wr", 64'(mem_write), 64'd1);
        chk("alt_mem_addr", mem_address, 64'd40);
        chk("alt_dones_serve", 64'({r0_done, r1_done}), 64'd0);
        tick();
        chk("alt_r1_done", 64'(r1_done), 64'd1);
        chk("alt_r0_done1", 64'(r0_done), 64'd0);
        chk("alt_mem40", tb_mem[5], 64'hCAFE_F00D_0000_0028);
        tick();

        // Reset during SERVE of an r0 write to 8
        r0_req = 1; r0_we = 1; r0_addr = 64'd8; r0_wdata = 64'hDEAD_BEEF_DEAD_BEEF;
        tick(); r0_req = 0;
        chk("rs_pre_wr", 64'(mem_write), 64'd1);
        rst_n = 1'b0;
        #1 chk("rs_wr_gated", 64'(mem_write), 64'd0);
        tick();
        chk("rs_done0", 64'(r0_done), 64'd0);
        chk("rs_wr_after", 64'(mem_write), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rs_done1", 64'(r0_done), 64'd0);
        r0_req = 1; r0_we = 0; r0_addr = 64'd8;
        tick(); r0_req = 0;
        chk("rs_rd_mem_read", 64'(mem_read), 64'd1);
        tick();
        chk("rs_rd_done", 64'(r0_done), 64'd1);
        chk("rs_rd_rdata", r0_rdata, 64'h0123_4567_0000_0001);
        tick();

        // Idle 10 cycles
        for (int i = 0; i < 10; i++) begin
            chk("idle_flags", 64'({r0_gnt, r1_gnt, r0_done, r1_done, r0_err, r1_err, mem_read, mem_write}), 64'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-ported 64-bit, byte-addressable data memory between two requesters.
  - Requester 0 is the core load/store path.
  - Requester 1 is the debug/program-loader port.
- Uses a request/grant/done handshake with fixed priority to requester 0, plus a starvation counter that forces a grant to requester 1.
- Checks address range and alignment before touching memory, so an illegal access returns an error response instead of stopping the simulation.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; the highest legal doubleword address is MEM_BYTES-8.
- STARVE_LIMIT, 4, number of consecutive ungranted cycles on requester 1 that forces its grant; legal range 1..255.

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- r0_req, r1_req  in  1  request; must be held with its fields stable until the matching gnt
- r0_we, r1_we  in  1  1 = write, 0 = read
- r0_addr, r1_addr  in  64  byte address
- r0_wdata, r1_wdata  in  64  write data
- r0_gnt, r1_gnt  out  1  combinational; request accepted this cycle
- r0_done, r1_done  out  1  registered one-cycle completion pulse
- r0_err, r1_err  out  1  registered; qualified by done; illegal address
- r0_rdata, r1_rdata  out  64  registered read data; valid when done=1, err=0, and the transaction was a read
- mem_address  out  64  to data memory
- mem_write_data  out  64  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_read_data  in  64  from data memory; combinational read

Behaviour:
- Reset: one clock, synchronous, active-low.
  - While rst_n=0 at a posedge: state goes to IDLE; starve_cnt=0; all done/err=0; all rdata=0; latched request fields=0.
  - Outputs mem_read=mem_write=0 and mem_address=mem_write_data=0 whenever state is IDLE.
- FSM states: IDLE, SERVE, RESP.
  - In IDLE, at most one gnt is asserted, combinationally.
  - The winner's we/addr/wdata/id are latched on the same edge, and the next state is SERVE.
  - No request pending: stay in IDLE.
- Arbitration in IDLE:
  - If r1_req and starve_cnt >= STARVE_LIMIT: requester 1 wins.
  - Else if r0_req: requester 0 wins.
  - Else if r1_req: requester 1 wins.
- Starvation counter (starve_cnt, 8 bits, saturating at 255):
  - Cleared when r1 is granted or r1_req=0.
  - Otherwise incremented on every clock edge while r1_req=1 without r1_gnt, including SERVE and RESP cycles.
- Legality check on the latched address: legal iff addr <= MEM_BYTES-8 and addr[2:0]==0.
- SERVE (exactly one cycle), legal access:
  - mem_address=addr.
  - mem_write_data=wdata.
  - mem_write=we.
  - mem_read=!we.
  - On a read, mem_read_data is captured into the winner's rdata at the end of the cycle.
- SERVE, illegal access:
  - mem_read=mem_write=0.
  - rdata is loaded with 0.
  - err is set for the response.
- RESP (exactly one cycle):
  - The winner's done=1; err=1 if the access was illegal.
  - The other requester's done/err stay 0; rdata holds its last value.
  - RESP behaves as IDLE for arbitration, so a new grant is possible in RESP.
  - Back-to-back throughput: one transaction per 2 cycles.
- Latency: gnt in cycle T → memory access in T+1 → done in T+2.
- Simultaneous r0_req and r1_req with starve_cnt < STARVE_LIMIT: r0 wins; r1 keeps waiting and starve_cnt increments.
- Requests are not granted in SERVE.
- A req dropped before gnt is simply not served; it is not an error.
- Reset asserted during SERVE: no mem_write on that edge's successors, no done is ever issued for the dropped transaction, and the FSM returns to IDLE.

Test Plan:
- r0 write, addr=16, wdata=64'h1122334455667788: r0_gnt at T; at T+1 mem_write=1 and mem_address=16; r0_done=1, r0_err=0 at T+2. Then r0 read, addr=16: r0_rdata=64'h1122334455667788 with done.
- r1 read, addr=1017: r1_gnt; mem_read stays 0; r1_done=1, r1_err=1, r1_rdata=0. Repeat with addr=12 (misaligned): same error response.
- r0_req and r1_req held continuously, STARVE_LIMIT=4: first grants go to r0; r1 is granted on the first arbitration after starve_cnt reaches 4; starve_cnt then returns to 0.
- Alternating single requests: r0 read at T, r1 write in RESP cycle T+2. r1_gnt at T+2; r0_done at T+2, r1_done at T+4; done pulses never overlap.
- rst_n=0 during SERVE of an r0 write to addr=8: mem_write=0 from the reset edge onward; r0_done never pulses; a later read of addr=8 returns the pre-write contents.
- Idle with no requests for 10 cycles: all gnt/done/err=0 and mem_read=mem_write=0 throughout.
